// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module      : bcd_countdown_timer
// Description : Latches three BCD time digits (000-999 plain seconds) for the
//               current level and counts them down once per second to 000.
//               Flags expiry to the game controller and feeds the live
//               remaining time to the seven-segment display path.
//               Optional low-time warning output is built only when the
//               macro COUNTDOWN_WARN_EN is defined; otherwise warn is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer #(
    parameter int TICK_DIV  = 50000000,
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] value_three,
    input  logic [3:0] value_two,
    input  logic [3:0] value_one,
    output logic [3:0] digit_three,
    output logic [3:0] digit_two,
    output logic [3:0] digit_one,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse,
    output logic       warn
);

    // Prescaler is sized for the largest legal TICK_DIV (2^26-1).
    localparam int                 c_PRESC_W   = 26;
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOADED  = 3'd1,
        ST_RUN     = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_EXPIRED = 3'd4
    } state_t;

    // Any non-decimal input digit is treated as 9.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > 4'd9) ? 4'd9 : v;
    endfunction

    state_t               r_state;
    state_t               w_state_nxt;
    logic [3:0]           r_d3, r_d2, r_d1;
    logic [3:0]           w_d3_nxt, w_d2_nxt, w_d1_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [c_PRESC_W-1:0] w_presc_nxt;
    logic                 r_running;
    logic                 r_expired;
    logic                 r_expire_pulse;
    logic                 w_pulse_nxt;

    logic                 w_tick;
    logic                 w_is_zero;
    logic [3:0]           w_dec3, w_dec2, w_dec1;
    logic                 w_borrow1, w_borrow2;
    logic                 w_dec_zero;
    logic [c_PRESC_W-1:0] w_presc_inc;

    // Prescaler reached its last count while running: one second elapsed.
    assign w_tick      = (r_state == ST_RUN) && (r_presc == c_TICK_LAST);
    assign w_is_zero   = (r_d3 == 4'd0) && (r_d2 == 4'd0) && (r_d1 == 4'd0);
    // Saturating increment: the prescaler parks at its last count so a pause
    // landing on a tick keeps that tick pending for the first cycle of resume.
    assign w_presc_inc = (r_presc == c_TICK_LAST) ? r_presc : (r_presc + c_PRESC_ONE);

    // BCD decrement with ripple borrow from ones to tens to hundreds.
    always_comb begin
        w_borrow1  = (r_d1 == 4'd0);
        w_dec1     = w_borrow1 ? 4'd9 : (r_d1 - 4'd1);
        w_borrow2  = w_borrow1 && (r_d2 == 4'd0);
        w_dec2     = w_borrow1 ? ((r_d2 == 4'd0) ? 4'd9 : (r_d2 - 4'd1)) : r_d2;
        w_dec3     = (w_borrow2 && (r_d3 != 4'd0)) ? (r_d3 - 4'd1) : r_d3;
        w_dec_zero = (w_dec3 == 4'd0) && (w_dec2 == 4'd0) && (w_dec1 == 4'd0);
    end

    // Next-state, digit and prescaler selection; priority load > pause > start > tick.
    always_comb begin
        w_state_nxt = r_state;
        w_d3_nxt    = r_d3;
        w_d2_nxt    = r_d2;
        w_d1_nxt    = r_d1;
        w_presc_nxt = r_presc;
        w_pulse_nxt = 1'b0;

        if (load) begin
            w_state_nxt = ST_LOADED;
            w_d3_nxt    = clamp_bcd(value_three);
            w_d2_nxt    = clamp_bcd(value_two);
            w_d1_nxt    = clamp_bcd(value_one);
            w_presc_nxt = '0;
        end else if (pause && (r_state == ST_RUN)) begin
            // Partial second is kept; a coincident tick is suppressed.
            w_state_nxt = ST_PAUSED;
            w_presc_nxt = w_presc_inc;
        end else if (start && ((r_state == ST_LOADED) || (r_state == ST_PAUSED))) begin
            if (w_is_zero) begin
                w_state_nxt = ST_EXPIRED;
                w_pulse_nxt = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end else if (r_state == ST_RUN) begin
            if (w_tick) begin
                w_presc_nxt = '0;
                w_d3_nxt    = w_dec3;
                w_d2_nxt    = w_dec2;
                w_d1_nxt    = w_dec1;
                if (w_dec_zero) begin
                    w_state_nxt = ST_EXPIRED;
                    w_pulse_nxt = 1'b1;
                end
            end else begin
                w_presc_nxt = r_presc + c_PRESC_ONE;
            end
        end
    end

    // State, digit and prescaler registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_d3    <= 4'd0;
            r_d2    <= 4'd0;
            r_d1    <= 4'd0;
            r_presc <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_d3    <= w_d3_nxt;
            r_d2    <= w_d2_nxt;
            r_d1    <= w_d1_nxt;
            r_presc <= w_presc_nxt;
        end
    end

    // Status flags registered from the next state so they align with the digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_running      <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
        end else begin
            r_running      <= (w_state_nxt == ST_RUN);
            r_expired      <= (w_state_nxt == ST_EXPIRED);
            r_expire_pulse <= w_pulse_nxt;
        end
    end

    assign digit_three  = r_d3;
    assign digit_two    = r_d2;
    assign digit_one    = r_d1;
    assign running      = r_running;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;

`ifdef COUNTDOWN_WARN_EN
    localparam logic [31:0] c_WARN_LIM = WARN_SECS;

    logic [9:0] w_rem_bin;
    logic       r_warn;

    // Remaining time after this edge, converted from BCD to binary.
    assign w_rem_bin = (10'(w_d3_nxt) * 10'd100) + (10'(w_d2_nxt) * 10'd10) + 10'(w_d1_nxt);

    // Warning while counting or paused with a small, nonzero remaining time.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_warn <= 1'b0;
        end else begin
            r_warn <= ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSED))
                      && (w_rem_bin != 10'd0)
                      && ({22'd0, w_rem_bin} <= c_WARN_LIM);
        end
    end

    assign warn = r_warn;
`else
    localparam int c_unused_warn_secs = WARN_SECS;

    assign warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Scoreboard bench for bcd_countdown_timer (TICK_DIV=4,
//               WARN_SECS=3). Stimulus pushes cycle-tagged expectations; a
//               monitor pops and compares them on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

    logic       clk;
    logic       reset;
    logic       load;
    logic       start;
    logic       pause;
    logic [3:0] value_three, value_two, value_one;
    logic [3:0] digit_three, digit_two, digit_one;
    logic       running, expired, expire_pulse, warn;

    int cyc;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        string       name;
        logic [11:0] dg;
        logic        run;
        logic        exd;
        logic        pls;
        logic        wrn;
    } exp_t;

    exp_t sb[$];

    bcd_countdown_timer #(
        .TICK_DIV  (4),
        .WARN_SECS (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .start        (start),
        .pause        (pause),
        .value_three  (value_three),
        .value_two    (value_two),
        .value_one    (value_one),
        .digit_three  (digit_three),
        .digit_two    (digit_two),
        .digit_one    (digit_one),
        .running      (running),
        .expired      (expired),
        .expire_pulse (expire_pulse),
        .warn         (warn)
    );

    // Edge counter is bumped just before each rising edge, so edge k has cyc == k.
    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5;
            cyc = cyc + 1;
            clk = 1'b1;
            #5;
            clk = 1'b0;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got cyc=%0d required completion", cyc);
        $fatal(1);
    end

    // Warning is only expected when the optional feature is compiled in.
    function automatic logic wx(input logic x);
`ifdef COUNTDOWN_WARN_EN
        return x;
`else
        return 1'b0 & x;
`endif
    endfunction

    task automatic expect_at(input int c, input string nm, input logic [11:0] dg,
                             input logic run, input logic exd, input logic pls, input logic wrn);
        exp_t e;
        e.cyc  = c;
        e.name = nm;
        e.dg   = dg;
        e.run  = run;
        e.exd  = exd;
        e.pls  = pls;
        e.wrn  = wrn;
        sb.push_back(e);
    endtask

    // Monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp = n_cmp + 1;
            if (e.cyc < cyc) begin
                n_fail = n_fail + 1;
                $display("FAIL %s: expectation for cycle %0d checked late, got cycle %0d", e.name, e.cyc, cyc);
            end else if ({digit_three, digit_two, digit_one, running, expired, expire_pulse, warn}
                         !== {e.dg, e.run, e.exd, e.pls, e.wrn}) begin
                n_fail = n_fail + 1;
                $display("FAIL %s @cyc %0d: got digits=%h run=%b exp=%b pulse=%b warn=%b, required digits=%h run=%b exp=%b pulse=%b warn=%b",
                         e.name, cyc, {digit_three, digit_two, digit_one}, running, expired, expire_pulse, warn,
                         e.dg, e.run, e.exd, e.pls, e.wrn);
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic do_load(input logic [11:0] v, output int en);
        load        = 1'b1;
        value_three = v[11:8];
        value_two   = v[7:4];
        value_one   = v[3:0];
        @(posedge clk);
        en = cyc;
        #1;
        load = 1'b0;
    endtask

    task automatic do_start(output int en);
        start = 1'b1;
        @(posedge clk);
        en = cyc;
        #1;
        start = 1'b0;
    endtask

    task automatic do_pause(output int en);
        pause = 1'b1;
        @(posedge clk);
        en = cyc;
        #1;
        pause = 1'b0;
    endtask

    task automatic do_reset(output int en);
        reset = 1'b1;
        @(posedge clk);
        en = cyc;
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e, s, p, r, t, x;
        reset       = 1'b1;
        load        = 1'b0;
        start       = 1'b0;
        pause       = 1'b0;
        value_three = 4'd0;
        value_two   = 4'd0;
        value_one   = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        expect_at(cyc, "reset_state", 12'h000, 0, 0, 0, 0);
        reset = 1'b0;

        do_start(s);
        expect_at(s, "idle_start_ignored", 12'h000, 0, 0, 0, 0);

        // 200 counts down with a borrow through both upper digits
        do_load(12'h200, e);
        expect_at(e, "load_200", 12'h200, 0, 0, 0, 0);
        do_start(s);
        expect_at(s,     "run_200",        12'h200, 1, 0, 0, 0);
        expect_at(s + 3, "before_tick_200", 12'h200, 1, 0, 0, 0);
        expect_at(s + 4, "tick_199",       12'h199, 1, 0, 0, 0);
        expect_at(s + 7, "hold_199",       12'h199, 1, 0, 0, 0);
        expect_at(s + 8, "tick_198",       12'h198, 1, 0, 0, 0);
        wait_until(s + 8);

        // Expiry from 002
        do_load(12'h002, e);
        expect_at(e, "load_002", 12'h002, 0, 0, 0, 0);
        do_start(s);
        expect_at(s,     "run_002",         12'h002, 1, 0, 0, wx(1));
        expect_at(s + 4, "tick_001",        12'h001, 1, 0, 0, wx(1));
        expect_at(s + 8, "expire_000",      12'h000, 0, 1, 1, 0);
        expect_at(s + 9, "pulse_one_cycle", 12'h000, 0, 1, 0, 0);
        wait_until(s + 10);
        do_start(t);
        expect_at(t, "start_in_expired", 12'h000, 0, 1, 0, 0);

        // Pause keeps the partial second
        do_load(12'h010, e);
        do_start(s);
        wait_until(s + 1);
        do_pause(p);
        expect_at(p,      "pause_010",     12'h010, 0, 0, 0, 0);
        expect_at(p + 10, "paused_hold",   12'h010, 0, 0, 0, 0);
        expect_at(p + 20, "paused_20",     12'h010, 0, 0, 0, 0);
        wait_until(p + 20);
        do_start(r);
        expect_at(r,     "resume_010",      12'h010, 1, 0, 0, 0);
        expect_at(r + 1, "resume_partial",  12'h010, 1, 0, 0, 0);
        expect_at(r + 2, "resume_tick_009", 12'h009, 1, 0, 0, 0);
        wait_until(r + 2);

        // Load coinciding with a tick wins
        do_load(12'h055, e);
        do_start(s);
        expect_at(s + 3, "pre_tick_055",    12'h055, 1, 0, 0, 0);
        expect_at(s + 4, "load_beats_tick", 12'h030, 0, 0, 0, 0);
        expect_at(s + 5, "loaded_030",      12'h030, 0, 0, 0, 0);
        expect_at(s + 8, "loaded_no_dec",   12'h030, 0, 0, 0, 0);
        wait_until(s + 3);
        do_load(12'h030, x);
        wait_until(s + 8);

        // Pause coinciding with a tick wins; tick fires right after resume
        do_load(12'h020, e);
        do_start(s);
        expect_at(s + 4, "pause_beats_tick", 12'h020, 0, 0, 0, 0);
        expect_at(s + 6, "paused_020",       12'h020, 0, 0, 0, 0);
        wait_until(s + 3);
        do_pause(p);
        wait_until(s + 6);
        do_start(r);
        expect_at(r,     "resume_020",        12'h020, 1, 0, 0, 0);
        expect_at(r + 1, "tick_after_resume", 12'h019, 1, 0, 0, 0);
        wait_until(r + 1);

        // Start on 000 expires immediately; clamping of non-BCD inputs
        do_load(12'h000, e);
        expect_at(e, "load_000", 12'h000, 0, 0, 0, 0);
        do_start(s);
        expect_at(s,     "start_zero_expires", 12'h000, 0, 1, 1, 0);
        expect_at(s + 1, "zero_pulse_once",    12'h000, 0, 1, 0, 0);
        wait_until(s + 1);
        do_load(12'hFFF, e);
        expect_at(e, "clamp_fff", 12'h999, 0, 0, 0, 0);
        do_load(12'h3B7, e);
        expect_at(e, "clamp_mixed", 12'h397, 0, 0, 0, 0);

        // Warning window 3..1 seconds
        do_load(12'h005, e);
        do_start(s);
        expect_at(s,      "warn_run_005", 12'h005, 1, 0, 0, 0);
        expect_at(s + 4,  "warn_004",     12'h004, 1, 0, 0, 0);
        expect_at(s + 8,  "warn_003",     12'h003, 1, 0, 0, wx(1));
        expect_at(s + 12, "warn_002",     12'h002, 1, 0, 0, wx(1));
        expect_at(s + 16, "warn_001",     12'h001, 1, 0, 0, wx(1));
        expect_at(s + 20, "warn_000",     12'h000, 0, 1, 1, 0);
        wait_until(s + 20);

        // Reset mid-run clears everything without an expiry pulse
        do_load(12'h005, e);
        do_start(s);
        expect_at(s + 8, "pre_reset_003", 12'h003, 1, 0, 0, wx(1));
        wait_until(s + 9);
        do_reset(x);
        expect_at(x,     "reset_midrun",   12'h000, 0, 0, 0, 0);
        expect_at(x + 1, "reset_no_pulse", 12'h000, 0, 0, 0, 0);
        wait_until(x + 1);
        do_start(t);
        expect_at(t, "start_after_reset", 12'h000, 0, 0, 0, 0);
        wait_until(t + 2);

        if (sb.size() != 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL scoreboard_drain: got %0d pending expectations, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
